// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
package serial_adder_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_t;

endpackage

// File: rtl/fa_cell.sv
// Purely combinational 1-bit full adder cell.
module fa_cell (
    input  logic A,
    input  logic B,
    input  logic ci,
    output logic co,
    output logic s
);

    // Sum is the parity of the three inputs; carry is their majority.
    always_comb begin
        s  = A ^ B ^ ci;
        co = (A & B) | (A & ci) | (B & ci);
    end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: streams operand bit pairs LSB first through one full-adder cell,
// holding the carry in a flop, and publishes the assembled sum with a one-cycle done pulse.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co
);

    state_t             state;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [WIDTH-1:0]   sum_sh;
    logic               carry;
    logic [CNT_W-1:0]   cnt;

    logic               cell_s;
    logic               cell_co;
    logic [WIDTH-1:0]   sum_next;
    logic               last_bit;

    fa_cell u_fa_cell (
        .A  (a_sh[0]),
        .B  (b_sh[0]),
        .ci (carry),
        .co (cell_co),
        .s  (cell_s)
    );

    // New sum bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
    always_comb begin
        sum_next = {cell_s, sum_sh[WIDTH-1:1]};
        last_bit = (cnt == CNT_W'(WIDTH - 1));
    end

    // Sequencer: latches operands on start, shifts one bit per RUN cycle, publishes on the last.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= StIdle;
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            s      <= '0;
            co     <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh   <= A;
                        b_sh   <= B;
                        carry  <= ci;
                        cnt    <= '0;
                        sum_sh <= '0;
                        busy   <= 1'b1;
                        state  <= StRun;
                    end
                end
                StRun: begin
                    sum_sh <= sum_next;
                    carry  <= cell_co;
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    cnt    <= cnt + CNT_W'(1);
                    if (last_bit) begin
                        s     <= sum_next;
                        co    <= cell_co;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= StDone;
                    end
                end
                StDone: begin
                    done  <= 1'b0;
                    state <= StIdle;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Randomized scoreboard bench for serial_adder plus a standalone check of fa_cell.
module tb_serial_adder;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         ci = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] s;
    logic         co;

    logic fa_a = 1'b0, fa_b = 1'b0, fa_ci = 1'b0;
    logic fa_co, fa_s;

    int checks = 0;
    int failures = 0;

    logic [W:0] exp_q[$];
    int         done_cycles[$];
    logic [W:0] held = '0;
    logic       prev_done = 1'b0;
    logic       mon_en = 1'b0;
    int         cyc = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .ci    (ci),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .co    (co)
    );

    fa_cell u_fa (
        .A  (fa_a),
        .B  (fa_b),
        .ci (fa_ci),
        .co (fa_co),
        .s  (fa_s)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no end, required end of test");
        $fatal(1, "watchdog");
    end

    // Reference result: plain integer addition truncated to W+1 bits.
    function automatic logic [W:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic c);
        int unsigned t;
        t = int'(a) + int'(b) + int'(c);
        return t[W:0];
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, want);
        end
    endtask

    // Monitor: pops the scoreboard on every done pulse; otherwise outputs must hold.
    always @(negedge clk) begin
        if (!rst && mon_en) begin
            if (done) begin
                check("done_width", 32'(prev_done), 32'd0);
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_done: got done with s=0x%0h co=%0b, required none",
                             s, co);
                end else begin
                    logic [W:0] e;
                    e = exp_q.pop_front();
                    if ({co, s} !== e) begin
                        failures++;
                        $display("FAIL result: got {co,s}=0x%0h, required 0x%0h", {co, s}, e);
                    end
                    held = e;
                end
                done_cycles.push_back(cyc);
            end else begin
                check("hold", 32'({co, s}), 32'(held));
            end
            prev_done = done;
        end
    end

    // Issues one addition, checks busy across RUN and the DONE cycle, then returns in IDLE.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        A = a; B = b; ci = c; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        exp_q.push_back(ref_sum(a, b, c));
        // Later operand changes must not matter.
        A = W'($urandom); B = W'($urandom); ci = 1'($urandom);
        for (int i = 0; i < int'(W); i++) begin
            check("busy_run", 32'(busy), 32'd1);
            @(posedge clk); #1;
        end
        check("busy_done", 32'(busy), 32'd0);
        check("done_cycle", 32'(done), 32'd1);
        @(posedge clk); #1;
        check("pending", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        // fa_cell truth table, 111 down to 000.
        for (int i = 7; i >= 0; i--) begin
            logic [2:0] v;
            v = 3'(i);
            fa_a = v[2]; fa_b = v[1]; fa_ci = v[0];
            #10;
            check("fa_cell", 32'({fa_co, fa_s}), 32'(v[2]) + 32'(v[1]) + 32'(v[0]));
        end

        // Reset state.
        rst = 1'b1;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_s", 32'(s), 32'd0);
        check("rst_co", 32'(co), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        mon_en = 1'b1;
        @(posedge clk); #1;

        // Directed cases.
        issue(8'h5A, 8'h3C, 1'b0);
        issue(8'hFF, 8'h01, 1'b0);
        issue(8'hFF, 8'hFF, 1'b1);

        // Start during RUN is ignored.
        A = 8'h10; B = 8'h20; ci = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        exp_q.push_back(ref_sum(8'h10, 8'h20, 1'b0));
        repeat (2) begin @(posedge clk); #1; end
        A = 8'h01; B = 8'h01; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (12) begin @(posedge clk); #1; end
        check("ignored_start", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset mid-operation discards the addition.
        A = 8'h33; B = 8'h44; ci = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        exp_q.push_back(ref_sum(8'h33, 8'h44, 1'b1));
        repeat (3) begin @(posedge clk); #1; end
        #1 rst = 1'b1;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_s", 32'(s), 32'd0);
        check("mid_rst_co", 32'(co), 32'd0);
        exp_q.delete();
        held = '0;
        prev_done = 1'b0;
        rst = 1'b0;
        repeat (14) begin @(posedge clk); #1; end
        issue(8'h01, 8'h02, 1'b1);

        // Back-to-back with start held high: accepts at three edges, 10 cycles apart.
        begin
            int n0;
            n0 = done_cycles.size();
            A = 8'h7F; B = 8'h01; ci = 1'b0; start = 1'b1;
            for (int k = 0; k < 3; k++) exp_q.push_back(ref_sum(8'h7F, 8'h01, 1'b0));
            repeat (21) begin @(posedge clk); #1; end
            start = 1'b0;
            repeat (14) begin @(posedge clk); #1; end
            check("b2b_count", 32'(done_cycles.size() - n0), 32'd3);
            check("b2b_pending", 32'(exp_q.size()), 32'd0);
            if (done_cycles.size() - n0 == 3) begin
                check("b2b_period1", 32'(done_cycles[n0 + 1] - done_cycles[n0]), 32'd10);
                check("b2b_period2", 32'(done_cycles[n0 + 2] - done_cycles[n0 + 1]), 32'd10);
            end
        end

        // Randomized operands.
        for (int i = 0; i < 25; i++) begin
            issue(W'($urandom), W'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
